// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: serialises two masters onto the peripheral bus, one 3-cycle transaction at a time
module periph_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              p_rd,
    output logic              p_wr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_r_accessible,
    input  logic              p_w_accessible,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d, cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [DATA_W-1:0] p_wdata_q, p_wdata_d, rdata_q, rdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              err_q, err_d, m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic              start, pick, rd_cap, done_err;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? ((m0_req || m1_req) ? ISSUE : IDLE) :
                  (state_q == ISSUE) ? DONE : IDLE;
    end

    // last_grant also names the owner of the transaction in flight
    always_comb begin
        start        = state_q == IDLE && (m0_req || m1_req);
        pick         = (PRIO_MODE == 0 && m0_req && m1_req) ? ~last_grant_q : ~m0_req;
        last_grant_d = start ? pick : last_grant_q;
        cmd_wr_d     = start ? (pick ? m1_wr : m0_wr) : cmd_wr_q;
        p_addr_d     = start ? (pick ? m1_addr : m0_addr) : p_addr_q;
        p_wdata_d    = start ? (pick ? m1_wdata : m0_wdata) : p_wdata_q;
        rd_cap       = state_q == ISSUE && !cmd_wr_q;
        rdata_d      = rd_cap ? p_rdata : rdata_q;
        err_d        = rd_cap ? ~p_r_accessible : err_q;
        m0_rdata_d   = m0_rdata;
        m0_err_d     = m0_err;
        m1_rdata_d   = m1_rdata;
        m1_err_d     = m1_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            cmd_wr_q     <= 1'b0;
            p_addr_q     <= '0;
            p_wdata_q    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            m0_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
            m1_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cmd_wr_q     <= cmd_wr_d;
            p_addr_q     <= p_addr_d;
            p_wdata_q    <= p_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            m0_rdata_q   <= m0_rdata_d;
            m0_err_q     <= m0_err_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_err_q     <= m1_err_d;
        end
    end

    // write hit arrives registered, so it is only meaningful in DONE
    always_comb begin
        done_err = cmd_wr_q ? ~p_w_accessible : err_q;
        m0_ack   = state_q == DONE && !last_grant_q;
        m1_ack   = state_q == DONE && last_grant_q;
        m0_rdata = m0_ack ? rdata_q : m0_rdata_q;
        m0_err   = m0_ack ? done_err : m0_err_q;
        m1_rdata = m1_ack ? rdata_q : m1_rdata_q;
        m1_err   = m1_ack ? done_err : m1_err_q;
        p_rd     = state_q == ISSUE && !cmd_wr_q;
        p_wr     = state_q == ISSUE && cmd_wr_q;
        p_addr   = p_addr_q;
        p_wdata  = p_wdata_q;
        busy     = state_q != IDLE;
    end
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_periph_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m0_ack, m0_err, m1_req, m1_wr, m1_ack, m1_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        p_rd, p_wr, p_r_accessible, p_w_accessible, busy;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic [31:0] env_regs [8];

    logic        f_m0_req, f_m1_req, f_m0_ack, f_m1_ack, f_m0_err, f_m1_err;
    logic        f_p_rd, f_p_wr, f_busy, f_one, f_zbit;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_p_addr, f_p_wdata, f_zero;

    int          checks = 0;
    int          failures = 0;
    bit          hold, rnd;

    int          phase;
    logic        own, lastg, exp_wr, exp_er, h0_er, h1_er;
    logic [31:0] exp_addr, exp_wd, exp_rd, last_rd, h0_rd, h1_rd;
    logic [31:0] mmem [8];
    logic [31:0] addrs [8] = '{32'h40000000, 32'h40000004, 32'h40000008, 32'h4000000C,
                               32'h40000010, 32'h40000014, 32'h40000018, 32'h40000020};

    always #5 clk = ~clk;

    periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_r_accessible(p_r_accessible), .p_w_accessible(p_w_accessible),
        .busy(busy)
    );

    periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_req(f_m0_req), .m0_wr(f_zbit), .m0_addr(f_zero), .m0_wdata(f_zero),
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
        .m1_req(f_m1_req), .m1_wr(f_zbit), .m1_addr(f_zero), .m1_wdata(f_zero),
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
        .p_rd(f_p_rd), .p_wr(f_p_wr), .p_addr(f_p_addr), .p_wdata(f_p_wdata),
        .p_rdata(f_zero), .p_r_accessible(f_one), .p_w_accessible(f_one),
        .busy(f_busy)
    );

    // Peripheral map: 0x00..0x10 read/write, 0x14 read-only switch (0xA5), rest unmapped
    function automatic logic rok(input logic [31:0] a);
        return a[31:5] == 27'h2000000 && a[1:0] == 2'b00 && a[4:2] <= 3'd5;
    endfunction
    function automatic logic wok(input logic [31:0] a);
        return a[31:5] == 27'h2000000 && a[1:0] == 2'b00 && a[4:2] <= 3'd4;
    endfunction

    always_comb begin
        p_r_accessible = rok(p_addr);
        p_rdata = !p_r_accessible ? 32'h0 : (p_addr[4:2] == 3'd5) ? 32'hA5 : env_regs[p_addr[4:2]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) env_regs[i] <= '0;
            p_w_accessible <= 1'b0;
        end else begin
            p_w_accessible <= p_wr && wok(p_addr);
            if (p_wr && wok(p_addr)) env_regs[p_addr[4:2]] <= p_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the transaction model, compare every output, then act as the masters
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            phase = 0; lastg = 1'b1; own = 1'b0; exp_wr = 1'b0;
            exp_addr = 0; exp_wd = 0; exp_rd = 0; exp_er = 0; last_rd = 0;
            h0_rd = 0; h0_er = 0; h1_rd = 0; h1_er = 0;
            for (int i = 0; i < 8; i++) mmem[i] = 0;
        end else if (phase == 0 && (m0_req || m1_req)) begin
            own      = (m0_req && m1_req) ? !lastg : m1_req;
            lastg    = own;
            exp_wr   = own ? m1_wr : m0_wr;
            exp_addr = own ? m1_addr : m0_addr;
            exp_wd   = own ? m1_wdata : m0_wdata;
            if (exp_wr) begin
                exp_er = !wok(exp_addr);
                if (wok(exp_addr)) mmem[exp_addr[4:2]] = exp_wd;
                exp_rd = last_rd;
            end else begin
                exp_er  = !rok(exp_addr);
                exp_rd  = !rok(exp_addr) ? 32'h0 : (exp_addr[4:2] == 3'd5) ? 32'hA5 : mmem[exp_addr[4:2]];
                last_rd = exp_rd;
            end
            phase = 1;
        end else begin
            phase = (phase == 1) ? 2 : 0;
        end
        #1;
        chk("busy", busy, phase != 0);
        chk("p_rd", p_rd, phase == 1 && !exp_wr);
        chk("p_wr", p_wr, phase == 1 && exp_wr);
        chk("p_addr", p_addr, exp_addr);
        chk("p_wdata", p_wdata, exp_wd);
        chk("m0_ack", m0_ack, phase == 2 && !own);
        chk("m1_ack", m1_ack, phase == 2 && own);
        chk("m0_rdata", m0_rdata, (phase == 2 && !own) ? exp_rd : h0_rd);
        chk("m0_err", m0_err, (phase == 2 && !own) ? exp_er : h0_er);
        chk("m1_rdata", m1_rdata, (phase == 2 && own) ? exp_rd : h1_rd);
        chk("m1_err", m1_err, (phase == 2 && own) ? exp_er : h1_er);
        if (phase == 2 && own) begin h1_rd = exp_rd; h1_er = exp_er; end
        if (phase == 2 && !own) begin h0_rd = exp_rd; h0_er = exp_er; end
        if (!hold && m0_ack) m0_req = 1'b0;
        if (!hold && m1_ack) m1_req = 1'b0;
        if (rnd && !m0_req && $urandom_range(0, 2) == 0) begin
            m0_req = 1'b1; m0_wr = 1'($urandom_range(0, 1));
            m0_addr = addrs[$urandom_range(0, 7)]; m0_wdata = $urandom;
        end
        if (rnd && !m1_req && $urandom_range(0, 2) == 0) begin
            m1_req = 1'b1; m1_wr = 1'($urandom_range(0, 1));
            m1_addr = addrs[$urandom_range(0, 7)]; m1_wdata = $urandom;
        end
    endtask

    task automatic tx(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
        rd = 0; er = 0;
        if (m) begin m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = wd; end
        else begin m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = wd; end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("ack_latency", m ? m1_ack : m0_ack, i == 2);
            if (i == 2) begin rd = m ? m1_rdata : m0_rdata; er = m ? m1_err : m0_err; end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          order[$], at[$], n;
        reset = 1'b1; hold = 0; rnd = 0;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
        f_m0_req = 0; f_m1_req = 0; f_one = 1'b1; f_zbit = 1'b0; f_zero = 32'h0;
        repeat (3) cycle();
        chk("reset_busy", busy, 0);
        chk("reset_p_addr", p_addr, 0);
        reset = 1'b0;
        cycle();

        tx(0, 0, 32'h40000014, 32'h0, rd, er);
        chk("m0_read_data", rd, 32'hA5);
        chk("m0_read_err", er, 0);
        tx(1, 1, 32'h40000010, 32'h3C, rd, er);
        chk("m1_write_err", er, 0);
        tx(1, 0, 32'h40000010, 32'h0, rd, er);
        chk("m1_readback", rd, 32'h3C);
        tx(0, 0, 32'h40000020, 32'h0, rd, er);
        chk("unmapped_read_err", er, 1);
        tx(1, 1, 32'h40000014, 32'h55, rd, er);
        chk("readonly_write_err", er, 1);

        hold = 1;
        m0_req = 1; m0_wr = 0; m0_addr = 32'h40000000;
        m1_req = 1; m1_wr = 1; m1_addr = 32'h40000004; m1_wdata = 32'h1234;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (m0_ack) begin order.push_back(0); at.push_back(i); end
            if (m1_ack) begin order.push_back(1); at.push_back(i); end
        end
        hold = 0; m0_req = 0; m1_req = 0;
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < order.size()) begin
                chk("rr_order", order[k], k % 2);
                chk("rr_spacing", at[k], 2 + 3 * k);
            end
        end
        cycle();

        m0_req = 1; m0_wr = 0; m0_addr = 32'h40000000;
        cycle();
        chk("rst_pre_p_rd", p_rd, 1);
        reset = 1'b1;
        cycle();
        chk("rst_no_ack", m0_ack, 0);
        chk("rst_p_rd", p_rd, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h40000004;
        cycle();
        cycle();
        chk("rst_tie_m0", m0_ack, 1);
        repeat (4) cycle();

        f_m0_req = 1; f_m1_req = 1; n = 0;
        for (int i = 1; i <= 11; i++) begin
            cycle();
            chk("prio_m1_blocked", f_m1_ack, 0);
            if (f_m0_ack) n++;
        end
        chk("prio_m0_count", n, 4);
        f_m0_req = 0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("prio_m1_after_drop", f_m1_ack, i == 3);
        end
        f_m1_req = 0;
        cycle();
        chk("prio_idle", f_busy, 0);

        rnd = 1;
        repeat (600) cycle();
        rnd = 0;
        repeat (8) cycle();
        chk("final_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral bus (timer TH/TL/TCON, LED, switch, 7-seg digi registers) between two masters.
  - M0: CPU data port.
  - M1: an auxiliary master, e.g. a UART/DMA engine.
- Serialises accesses one transaction at a time and drives the peripheral's rd/wr/addr/wdata.
- Returns read data plus an access-error flag, derived from the peripheral's r_accessible/w_accessible, to the winning master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority (M0 always wins).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  M0 request; held high with command stable until m0_ack.
- m0_wr  input  1  M0 command: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  M0 address.
- m0_wdata  input  DATA_W  M0 write data.
- m0_ack  output  1  one-cycle completion pulse to M0.
- m0_rdata  output  DATA_W  M0 read data, valid when m0_ack.
- m0_err  output  1  M0 access error (unmapped address), valid when m0_ack.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  same as M0, for M1.
- p_rd  output  1  peripheral read strobe.
- p_wr  output  1  peripheral write strobe.
- p_addr  output  ADDR_W  peripheral address.
- p_wdata  output  DATA_W  peripheral write data.
- p_rdata  input  DATA_W  peripheral read data (combinational from p_addr).
- p_r_accessible  input  1  combinational read-hit flag.
- p_w_accessible  input  1  registered write-hit flag, valid the cycle after p_wr.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, highest priority) values:
  - State IDLE.
  - last_grant = 1, so M0 wins the first tie.
  - p_rd = p_wr = 0; p_addr = p_wdata = 0.
  - All ack/err = 0; rdata regs = 0; busy = 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req, pick owner:
    - PRIO_MODE=1: M0 if m0_req, else M1.
    - PRIO_MODE=0: sole requester wins; on a tie, the master != last_grant wins.
  - Latch owner's wr/addr/wdata into p_addr/p_wdata/cmd_wr; set last_grant = owner; go to ISSUE.
- ISSUE (exactly one cycle):
  - p_wr = cmd_wr, p_rd = ~cmd_wr.
  - For a read: capture p_rdata into rdata_q and ~p_r_accessible into err_q at the end of this cycle.
  - Go to DONE.
- DONE (one cycle):
  - p_rd = p_wr = 0.
  - owner's ack = 1 and rdata = rdata_q.
  - err = err_q for a read, ~p_w_accessible for a write; writes never update rdata_q.
  - Non-owner ack = 0.
  - Go to IDLE.
- Latency and throughput:
  - Latency req-seen-in-IDLE to ack = 2 cycles (ack in the 3rd cycle).
  - Throughput: one transaction per 3 cycles.
- m*_rdata/m*_err hold their last value outside ack; only the ack qualifies them.
- A req still high in the cycle after its ack is a new transaction; it is arbitrated in IDLE normally.
- A non-owner request arriving mid-transaction waits; it is never dropped.
- Request deasserted before ack: protocol violation, not required to be handled; the transaction completes on latched values regardless.
- p_addr/p_wdata hold their latched values between transactions (no glitching to the bus).
- Exactly one of p_rd/p_wr is high, and only in ISSUE; never both.
- Reset asserted in ISSUE or DONE:
  - Transaction aborted, no ack emitted.
  - A write strobed in ISSUE may already have taken effect in the peripheral; this is accepted.

Test Plan:
- Single M0 read, addr 0x40000014, p_rdata = 0x000000A5, p_r_accessible = 1:
  - p_rd high for exactly 1 cycle in ISSUE.
  - m0_ack 2 cycles after req seen; m0_rdata = 0xA5, m0_err = 0.
- M1 write addr 0x40000010, wdata 0x3C, model w_accessible = 1:
  - p_wr for 1 cycle with p_wdata = 0x3C.
  - m1_ack with m1_err = 0; m0_ack stays 0.
- Read of unmapped addr 0x40000020 (p_r_accessible = 0) and write to read-only 0x40000014 (w_accessible = 0):
  - Both complete with err = 1; no hang.
- PRIO_MODE=0, both req held continuously for 4 transactions:
  - Grant order M0, M1, M0, M1 (ack spacing 3 cycles).
- PRIO_MODE=1, both req continuous:
  - M1 never acked while m0_req is high; M1 acked in the first transaction after m0_req drops.
- Reset asserted in ISSUE of an M0 read:
  - No m0_ack; next cycle all outputs at reset values.
  - After release, tie grant goes to M0.
